systolic_feed_ctrl: RTL

Sequencer that sits between the 4-lane weight/activation ROM and the west edge of the 4×4 systolic array. On a `start` pulse it issues one ROM read per row, captures each returned 4-lane vector, and emits it with diagonal skew: lane i is delayed i cycles. Each lane carries a per-lane valid, and `done` pulses once the last skewed element has left. The ROM walks its rows with an internal pointer, so the controller also issues a one-cycle rewind to that pointer at the start of every tile.

---
 rtl/systolic_pkg.sv | 19 +
 rtl/systolic_skew_line.sv | 42 ++++
 rtl/systolic_feed_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array west-edge feed controller.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REWIND,
    ISSUE,
    DRAIN,
    DONE
  } feed_state_t;

  localparam int LANES = 4;

  // Issue counter must hold 0..ROWS, hence rows+1.
  function automatic int cnt_width(input int rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// DEPTH-stage data+valid delay line; data is forced to zero whenever its valid is low.
module systolic_skew_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic             pending
);

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] vld_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= '0;
      for (int s = 0; s < DEPTH; s++) data_r[s] <= '0;
    end else begin
      vld_r[0]  <= vld;
      data_r[0] <= vld ? d : '0;
      for (int s = 1; s < DEPTH; s++) begin
        vld_r[s]  <= vld_r[s-1];
        data_r[s] <= data_r[s-1];
      end
    end
  end

  assign q     = data_r[DEPTH-1];
  assign q_vld = vld_r[DEPTH-1];

  // Anything still travelling behind the output stage keeps the line non-empty next cycle.
  if (DEPTH > 1) begin : g_pend
    assign pending = |vld_r[DEPTH-2:0];
  end else begin : g_nopend
    assign pending = 1'b0;
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Reads ROWS vectors from the 4-lane ROM per tile and presents them diagonally
// skewed to the west edge of the 4x4 systolic array.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ROWS    = 4,
  parameter int ROM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rom_rewind,
  output logic             rom_rden,
  input  logic [WIDTH-1:0] rom_d0,
  input  logic [WIDTH-1:0] rom_d1,
  input  logic [WIDTH-1:0] rom_d2,
  input  logic [WIDTH-1:0] rom_d3,
  output logic [WIDTH-1:0] a0,
  output logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] a3,
  output logic [LANES-1:0] a_vld
);

  localparam int CW = cnt_width(ROWS);

  feed_state_t state, state_nxt;
  logic [CW-1:0]      issue_cnt;
  logic [ROM_LAT-1:0] tags;
  logic [WIDTH-1:0]   rom_d   [LANES];
  logic [WIDTH-1:0]   s0_data [LANES];
  logic               s0_vld;
  logic [WIDTH-1:0]   lane_q  [LANES];
  logic [LANES-1:0]   lane_vld;
  logic [LANES-1:0]   lane_pend;
  logic               tag_out;
  logic               last_issue;
  logic               pipe_empty;

  assign rom_d[0] = rom_d0;
  assign rom_d[1] = rom_d1;
  assign rom_d[2] = rom_d2;
  assign rom_d[3] = rom_d3;

  assign tag_out    = tags[ROM_LAT-1];
  assign last_issue = (issue_cnt == CW'(ROWS - 1));
  // Judged one cycle early so DONE lands right after the last lane-3 element.
  assign pipe_empty = (tags == '0) && !s0_vld && (lane_pend == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                  issue_cnt <= '0;
    else if (state == REWIND) issue_cnt <= '0;
    else if (state == ISSUE)  issue_cnt <= issue_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tags <= '0;
    end else begin
      tags[0] <= rom_rden;
      for (int i = 1; i < ROM_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld <= 1'b0;
      for (int l = 0; l < LANES; l++) s0_data[l] <= '0;
    end else begin
      s0_vld <= tag_out;
      for (int l = 0; l < LANES; l++) s0_data[l] <= tag_out ? rom_d[l] : '0;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    done       = 1'b0;
    rom_rewind = 1'b0;
    rom_rden   = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = REWIND;
      end
      REWIND: begin
        rom_rewind = 1'b1;
        state_nxt  = ISSUE;
      end
      ISSUE: begin
        rom_rden = 1'b1;
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lane_q[0]    = s0_data[0];
  assign lane_vld[0]  = s0_vld;
  assign lane_pend[0] = 1'b0;

  for (genvar g = 1; g < LANES; g++) begin : g_skew
    systolic_skew_line #(
      .WIDTH(WIDTH),
      .DEPTH(g)
    ) u_skew (
      .clk    (clk),
      .rst    (rst),
      .d      (s0_data[g]),
      .vld    (s0_vld),
      .q      (lane_q[g]),
      .q_vld  (lane_vld[g]),
      .pending(lane_pend[g])
    );
  end

  assign a0    = lane_q[0];
  assign a1    = lane_q[1];
  assign a2    = lane_q[2];
  assign a3    = lane_q[3];
  assign a_vld = lane_vld;

endmodule
